// File: rtl/uart_tx_framed.sv
// uart_tx_framed: UART transmitter with runtime baud divisor, parity,
// one/two stop bits and a small input FIFO. Frames go out LSB first and
// queued bytes follow each other with no idle clock between frames.
// Optional feature macro: UART_TX_PARITY_EN builds the PARITY state and
// honours parity_mode; without it parity_mode is ignored.
module uart_tx_framed #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          tx_valid,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_serial_out,
  output logic                          tx_active,
  output logic                          tx_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  // FIFO storage and pointers
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]           lvl_q, lvl_d;
  logic                  push, pop, fifo_empty;

  // Frame state
  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d, div_q, div_d, div_eff;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  stop2_q, stop2_d, two_q, two_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  serial_q, serial_d, active_q, active_d, done_q, done_d;
  logic                  bit_end;
  logic                  par_en_q, par_en_d, par_odd_q, par_odd_d;

  assign fifo_empty    = (lvl_q == '0);
  assign tx_ready      = (lvl_q != (PW+1)'(FIFO_DEPTH));
  assign fifo_level    = lvl_q;
  assign push          = tx_valid && tx_ready;
  assign tx_serial_out = serial_q;
  assign tx_active     = active_q;
  assign tx_done       = done_q;

  // Divisors below 2 would leave no room for a bit boundary, so clamp them.
  assign div_eff = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
  assign bit_end = (cnt_q == div_q - 1'b1);

`ifdef UART_TX_PARITY_EN
  assign par_en_d  = pop ? (parity_mode == 2'b01 || parity_mode == 2'b10) : par_en_q;
  assign par_odd_d = pop ? (parity_mode == 2'b10) : par_odd_q;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign par_en_d  = 1'b0;
  assign par_odd_d = 1'b0;
`endif

  // FIFO next state: write at wr pointer, read advance on pop, level tracks both
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (push) begin
      mem_d[wr_q] = tx_data;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // Frame FSM; line/active/done are registered from the current state so the
  // line lags the state by one clock (push E0 -> pop E1 -> line falls E2).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    stop2_d  = stop2_q;
    data_d   = data_q;
    div_d    = div_q;
    two_d    = two_q;
    pop      = 1'b0;
    serial_d = 1'b1;
    active_d = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        active_d = 1'b0;
        cnt_d    = '0;
        pop      = !fifo_empty;
      end
      START: begin
        serial_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        serial_d = data_q[bit_q];
        if (bit_end) begin
          cnt_d   = '0;
          stop2_d = 1'b0;
          if (bit_q == BW'(DATA_WIDTH-1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = par_odd_q ? ~^data_q : ^data_q;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            done_d  = 1'b1;
            pop     = !fifo_empty;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'bx;
        active_d = 1'bx;
        done_d   = 1'bx;
      end
    endcase
    // Frame start: capture the byte and this frame's line settings.
    if (pop) begin
      data_d  = mem_q[rd_q];
      div_d   = div_eff;
      two_d   = two_stop;
      cnt_d   = '0;
      state_d = START;
    end
  end

  // State and FIFO registers; reset flushes the FIFO and abandons any frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      div_q     <= DIV_WIDTH'(2);
      two_q     <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stop2_q   <= stop2_d;
      data_q    <= data_d;
      div_q     <= div_d;
      two_q     <= two_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: table of single frames, then hand-written
// latency, back-to-back FIFO fill, mid-frame baud change and async reset.
// A monitor pops expected frames from a scoreboard and checks the line
// clock by clock.
module tb_uart_tx_framed;

`ifdef UART_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        two_stop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [2:0]  fifo_level;
  logic        tx_serial_out;
  logic        tx_active;
  logic        tx_done;

  uart_tx_framed #(.DATA_WIDTH(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .tx_serial_out(tx_serial_out), .tx_active(tx_active),
    .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         hp;
    bit         pbit;
    bit         two;
  } rec_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] bdiv;
    logic [1:0]  pm;
    bit          two;
    int          exp_div;
    bit          exp_hp;
    bit          exp_pbit;
  } vec_t;

  rec_t sb[$];
  bit   mon_busy = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   fall_cnt = 0;
  logic prev_act = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int frame_len(input rec_t r);
    return (1 + 8 + (r.hp ? 1 : 0) + (r.two ? 2 : 1)) * r.div;
  endfunction

  function automatic logic exp_line(input rec_t r, input int k);
    int s;
    s = k / r.div;
    if (s == 0) return 1'b0;
    if (s <= 8) return r.data[s-1];
    if (r.hp && s == 9) return r.pbit;
    return 1'b1;
  endfunction

  // done pulses and falling edges of tx_active
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (prev_act === 1'b1 && tx_active === 1'b0) fall_cnt <= fall_cnt + 1;
    prev_act <= tx_active;
  end

  // Scoreboard monitor: one expected frame per record
  initial begin : monitor
    rec_t r;
    int n, len, bl, bd, ba;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        mon_busy = 1'b1;
        n = 0;
        while (tx_serial_out !== 1'b0 && n < 4000) begin
          @(negedge clk);
          n++;
        end
        if (tx_serial_out !== 1'b0) begin
          chk("frame_start", tx_serial_out, 0);
        end else begin
          len = frame_len(r);
          bl = 0; bd = 0; ba = 0;
          for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (tx_serial_out !== exp_line(r, k)) bl++;
            if (tx_done !== (k == len - 1)) bd++;
            if (tx_active !== 1'b1) ba++;
          end
          chk($sformatf("frame_line_%02h_div%0d", r.data, r.div), bl, 0);
          chk($sformatf("frame_done_%02h", r.data), bd, 0);
          chk($sformatf("frame_active_%02h", r.data), ba, 0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] d, input rec_t r, input bit add);
    int n;
    n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) chk("push_ready", tx_ready, 1);
    else if (add) sb.push_back(r);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", (sb.size() != 0 || mon_busy), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic rec_t mk(input logic [7:0] d, input int dv);
    rec_t r;
    r.data = d; r.div = dv; r.hp = 1'b0; r.pbit = 1'b0; r.two = 1'b0;
    return r;
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[10];
    rec_t r;
    int   db, fb, bad;

    tbl[0] = '{8'hA5, 16'd4, 2'b00, 1'b0, 4, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 16'd0, 2'b00, 1'b0, 2, 1'b0, 1'b0};
    tbl[2] = '{8'hC3, 16'd1, 2'b00, 1'b0, 2, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 16'd3, 2'b00, 1'b1, 3, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 16'd5, 2'b11, 1'b0, 5, 1'b0, 1'b0};
    tbl[5] = '{8'h07, 16'd4, 2'b01, 1'b0, 4, 1'b1, 1'b1};
    tbl[6] = '{8'h07, 16'd4, 2'b10, 1'b0, 4, 1'b1, 1'b0};
    tbl[7] = '{8'h5A, 16'd3, 2'b01, 1'b1, 3, 1'b1, 1'b0};
    tbl[8] = '{8'h5A, 16'd2, 2'b10, 1'b0, 2, 1'b1, 1'b1};
    tbl[9] = '{8'h07, 16'd4, 2'b00, 1'b1, 4, 1'b0, 1'b0};

    reset_n = 1'b0; baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_line", tx_serial_out, 1);
    chk("rst_active", tx_active, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", tx_ready, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single frames from the table
    for (int i = 0; i < 10; i++) begin
      baud_div = tbl[i].bdiv; parity_mode = tbl[i].pm; two_stop = tbl[i].two;
      r.data = tbl[i].data;
      r.div  = tbl[i].exp_div;
      r.hp   = tbl[i].exp_hp && PEN;
      r.pbit = tbl[i].exp_pbit;
      r.two  = tbl[i].two;
      push(tbl[i].data, r, 1'b1);
      tx_valid = 1'b0;
      drain();
    end

    // push-to-line latency
    baud_div = 16'd4; parity_mode = 2'b00; two_stop = 1'b0;
    push(8'h81, mk(8'h81, 4), 1'b1);
    tx_valid = 1'b0;
    chk("lat_e0_line", tx_serial_out, 1);
    chk("lat_e0_level", fifo_level, 1);
    @(negedge clk);
    chk("lat_e1_line", tx_serial_out, 1);
    chk("lat_e1_level", fifo_level, 0);
    @(negedge clk);
    chk("lat_e2_line", tx_serial_out, 0);
    chk("lat_e2_active", tx_active, 1);
    drain();

    // six bytes with tx_valid held: FIFO fills, frames run back-to-back
    db = done_cnt; fb = fall_cnt;
    for (int i = 0; i < 6; i++) begin
      push(8'h11 * (i + 1), mk(8'(8'h11 * (i + 1)), 4), 1'b1);
      if (i == 4) begin
        chk("full_level", fifo_level, 4);
        chk("full_ready", tx_ready, 0);
      end
    end
    tx_valid = 1'b0;
    drain();
    #1;
    chk("b2b_done_pulses", done_cnt - db, 6);
    chk("b2b_active_falls", fall_cnt - fb, 1);

    // baud_div change during a frame only affects the next one
    baud_div = 16'd4;
    push(8'h96, mk(8'h96, 4), 1'b1);
    push(8'h69, mk(8'h69, 8), 1'b1);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    baud_div = 16'd8;
    drain();
    baud_div = 16'd4;

    // async reset in the middle of a DATA bit
    push(8'h00, mk(8'h00, 4), 1'b0);
    push(8'h00, mk(8'h00, 4), 1'b0);
    tx_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_line", tx_serial_out, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_line", tx_serial_out, 1);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_active", tx_active, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_serial_out !== 1'b1 || tx_active !== 1'b0) bad++;
    end
    chk("post_rst_idle", bad, 0);
    chk("post_rst_level", fifo_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
